// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: in-flight writer record and forward-select encoding.
// Pure declarations, no timing or flow-control behaviour.
package hazard_pkg;

    // Widest register address a record can hold; narrower addresses are zero-extended.
    localparam int MAX_ADDR_W = 8;

    // Forward-select value meaning "read the register file, no bypass".
    localparam int FWD_REGFILE = 0;

    typedef struct packed {
        logic                  valid;
        logic [MAX_ADDR_W-1:0] dest;
        logic                  isLoad;
    } hazRec_t;

endpackage

// File: rtl/hazard_match.sv
// Priority matcher: finds the youngest valid in-flight writer of one source register.
// Purely combinational, zero latency, no flow control.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int SEL_W = 2
) (
    input  hazRec_t [DEPTH-1:0]   chain,
    input  logic [MAX_ADDR_W-1:0] srcAddr,
    input  logic                  useSrc,
    output logic                  hit,
    output logic [SEL_W-1:0]      matchStage,
    output logic                  matchIsLoad
);

    // Scan oldest to youngest so the lowest stage index is the last writer.
    always_comb begin
        hit         = 1'b0;
        matchStage  = SEL_W'(FWD_REGFILE);
        matchIsLoad = 1'b0;
        if (useSrc && (srcAddr != '0)) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (chain[k].valid && (chain[k].dest == srcAddr)) begin
                    hit         = 1'b1;
                    matchStage  = SEL_W'(k + 1);
                    matchIsLoad = chain[k].isLoad;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writers, raises load-use stalls and picks bypass sources for ID.
// Stall/forward are same-cycle combinational; cpu_en=0 freezes all state.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_en,
    input  logic              id_valid,
    input  logic              id_flush,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_useRs,
    input  logic              id_useRt,
    input  logic              id_ifWriteRegsFile,
    input  logic [ADDR_W-1:0] id_registerWriteAddress,
    input  logic              id_isLoad,
    output logic              shouldStall,
    output logic [SEL_W-1:0]  fwdSelRs,
    output logic [SEL_W-1:0]  fwdSelRt,
    output logic [31:0]       stallCount,
    output logic [3:0]        pendingCount
);

    localparam logic [SEL_W-1:0] LOAD_READY_SEL = SEL_W'(LOAD_READY);

    hazRec_t [DEPTH-1:0] chain;
    hazRec_t [DEPTH-1:0] chainNext;
    hazRec_t             newRec;
    logic [3:0]          pendNext;

    logic [MAX_ADDR_W-1:0] srcRs;
    logic [MAX_ADDR_W-1:0] srcRt;
    logic                  hitRs, hitRt;
    logic                  loadRs, loadRt;
    logic [SEL_W-1:0]      stageRs, stageRt;
    logic                  hazRs, hazRt;

    assign srcRs = MAX_ADDR_W'(id_rs);
    assign srcRt = MAX_ADDR_W'(id_rt);

    hazard_match #(
        .DEPTH (DEPTH),
        .SEL_W (SEL_W)
    ) u_matchRs (
        .chain       (chain),
        .srcAddr     (srcRs),
        .useSrc      (id_useRs),
        .hit         (hitRs),
        .matchStage  (stageRs),
        .matchIsLoad (loadRs)
    );

    hazard_match #(
        .DEPTH (DEPTH),
        .SEL_W (SEL_W)
    ) u_matchRt (
        .chain       (chain),
        .srcAddr     (srcRt),
        .useSrc      (id_useRt),
        .hit         (hitRt),
        .matchStage  (stageRt),
        .matchIsLoad (loadRt)
    );

    // A load is only a hazard until it reaches the first stage that can bypass its data.
    assign hazRs = hitRs & loadRs & (stageRs < LOAD_READY_SEL);
    assign hazRt = hitRt & loadRt & (stageRt < LOAD_READY_SEL);

    // Gated by rst so a stale chain never stalls or forwards while reset is held.
    assign shouldStall = ~rst & id_valid & ~id_flush & (hazRs | hazRt);
    assign fwdSelRs    = rst ? SEL_W'(FWD_REGFILE) : stageRs;
    assign fwdSelRt    = rst ? SEL_W'(FWD_REGFILE) : stageRt;

    always_comb begin
        newRec = '0;
        if (id_valid && !id_flush && !shouldStall && id_ifWriteRegsFile &&
            (id_registerWriteAddress != '0)) begin
            newRec.valid  = 1'b1;
            newRec.dest   = MAX_ADDR_W'(id_registerWriteAddress);
            newRec.isLoad = id_isLoad;
        end
    end

    always_comb begin
        chainNext[0] = newRec;
        for (int k = 1; k < DEPTH; k++) begin
            chainNext[k] = chain[k-1];
        end
    end

    always_comb begin
        pendNext = 4'd0;
        for (int k = 0; k < DEPTH; k++) begin
            pendNext = pendNext + 4'(chainNext[k].valid);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chain        <= '0;
            stallCount   <= 32'd0;
            pendingCount <= 4'd0;
        end else if (cpu_en) begin
            chain        <= chainNext;
            pendingCount <= pendNext;
            if (shouldStall && (stallCount != 32'hFFFF_FFFF)) begin
                stallCount <= stallCount + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: default scoreboard (DEPTH=3, LOAD_READY=2) and a deep one (DEPTH=5, LOAD_READY=4)
// share one set of ID inputs; each scenario checks hand-computed stall/forward/counter values.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_en;
    logic       id_valid;
    logic       id_flush;
    logic [4:0] id_rs, id_rt;
    logic       id_useRs, id_useRt;
    logic       id_ifWriteRegsFile;
    logic [4:0] id_registerWriteAddress;
    logic       id_isLoad;

    logic        stallA, stallB;
    logic [1:0]  fwdRsA, fwdRtA;
    logic [2:0]  fwdRsB, fwdRtB;
    logic [31:0] stallCntA, stallCntB;
    logic [3:0]  pendA, pendB;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dutA (
        .clk(clk), .rst(rst), .cpu_en(cpu_en), .id_valid(id_valid), .id_flush(id_flush),
        .id_rs(id_rs), .id_rt(id_rt), .id_useRs(id_useRs), .id_useRt(id_useRt),
        .id_ifWriteRegsFile(id_ifWriteRegsFile), .id_registerWriteAddress(id_registerWriteAddress),
        .id_isLoad(id_isLoad), .shouldStall(stallA), .fwdSelRs(fwdRsA), .fwdSelRt(fwdRtA),
        .stallCount(stallCntA), .pendingCount(pendA)
    );

    hazard_scoreboard #(.DEPTH(5), .LOAD_READY(4)) dutB (
        .clk(clk), .rst(rst), .cpu_en(cpu_en), .id_valid(id_valid), .id_flush(id_flush),
        .id_rs(id_rs), .id_rt(id_rt), .id_useRs(id_useRs), .id_useRt(id_useRt),
        .id_ifWriteRegsFile(id_ifWriteRegsFile), .id_registerWriteAddress(id_registerWriteAddress),
        .id_isLoad(id_isLoad), .shouldStall(stallB), .fwdSelRs(fwdRsB), .fwdSelRt(fwdRtB),
        .stallCount(stallCntB), .pendingCount(pendB)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs then change 1 time unit later and are checked 2 units after that.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic setId(input logic v, input logic wr, input logic [4:0] wd, input logic ld,
                         input logic [4:0] rs, input logic uRs, input logic [4:0] rt, input logic uRt);
        id_valid                = v;
        id_flush                = 1'b0;
        id_ifWriteRegsFile      = wr;
        id_registerWriteAddress = wd;
        id_isLoad               = ld;
        id_rs                   = rs;
        id_useRs                = uRs;
        id_rt                   = rt;
        id_useRt                = uRt;
    endtask

    task automatic drain();
        setId(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        repeat (5) cyc();
    endtask

    initial begin
        rst    = 1'b1;
        cpu_en = 1'b1;
        setId(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);

        // Reset
        settle();
        check("rst_stall_during", {31'd0, stallA}, 32'd0);
        check("rst_fwdRs_during", {30'd0, fwdRsA}, 32'd0);
        cyc(); cyc();
        rst = 1'b0;
        settle();
        check("rst_stallCntA", stallCntA, 32'd0);
        check("rst_pendA", {28'd0, pendA}, 32'd0);
        check("rst_pendB", {28'd0, pendB}, 32'd0);
        check("rst_fwdRtA", {30'd0, fwdRtA}, 32'd0);

        // add r3 ; add r4,r3,r5 -> forward rs from stage 1
        setId(1'b1, 1'b1, 5'd3, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);
        settle();
        check("add1_fwdRs", {30'd0, fwdRsA}, 32'd0);
        cyc();
        setId(1'b1, 1'b1, 5'd4, 1'b0, 5'd3, 1'b1, 5'd5, 1'b1);
        settle();
        check("alu_fwdRs", {30'd0, fwdRsA}, 32'd1);
        check("alu_fwdRt", {30'd0, fwdRtA}, 32'd0);
        check("alu_stall", {31'd0, stallA}, 32'd0);
        check("alu_pend", {28'd0, pendA}, 32'd1);
        cyc();
        drain();
        check("drain_pend", {28'd0, pendA}, 32'd0);

        // lw r2 ; use r2 -> one stall then forward from stage 2
        setId(1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc();
        setId(1'b1, 1'b1, 5'd6, 1'b0, 5'd2, 1'b1, 5'd0, 1'b1);
        settle();
        check("lu_stall1", {31'd0, stallA}, 32'd1);
        cyc();
        settle();
        check("lu_stall2", {31'd0, stallA}, 32'd0);
        check("lu_fwdRs", {30'd0, fwdRsA}, 32'd2);
        check("lu_stallCnt", stallCntA, 32'd1);
        check("lu_pend_bubble", {28'd0, pendA}, 32'd1);
        cyc();
        drain();

        // lw r9 ; rt reader: invalid, flushed, then live
        setId(1'b1, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc();
        setId(1'b0, 1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        settle();
        check("invalid_nostall", {31'd0, stallA}, 32'd0);
        id_valid = 1'b1;
        settle();
        check("rt_hazard_stall", {31'd0, stallA}, 32'd1);
        id_flush = 1'b1;
        settle();
        check("flush_nostall", {31'd0, stallA}, 32'd0);
        cyc();
        id_flush = 1'b0;
        settle();
        check("flush_bubble_pend", {28'd0, pendA}, 32'd1);
        check("flush_stallCnt", stallCntA, 32'd1);
        drain();

        // r7 in stages 1 and 3, r8 in stage 2
        setId(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc();
        id_registerWriteAddress = 5'd8;
        cyc();
        id_registerWriteAddress = 5'd7;
        cyc();
        setId(1'b1, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 5'd7, 1'b1);
        settle();
        check("youngest_fwdRt", {30'd0, fwdRtA}, 32'd1);
        check("mid_fwdRs", {30'd0, fwdRsA}, 32'd2);
        check("three_pend", {28'd0, pendA}, 32'd3);
        id_useRs = 1'b0;
        settle();
        check("unused_fwdRs", {30'd0, fwdRsA}, 32'd0);
        id_useRs = 1'b1;
        cyc();
        settle();
        check("aged_fwdRt", {30'd0, fwdRtA}, 32'd2);
        check("wb_fwdRs", {30'd0, fwdRsA}, 32'd3);
        drain();

        // load writing r0 is never tracked
        setId(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc();
        setId(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
        settle();
        check("r0_pend", {28'd0, pendA}, 32'd0);
        check("r0_fwdRs", {30'd0, fwdRsA}, 32'd0);
        check("r0_stall", {31'd0, stallA}, 32'd0);
        drain();

        // freeze during a load-use stall
        setId(1'b1, 1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc();
        setId(1'b1, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 5'd0, 1'b0);
        settle();
        check("frz_stall_pre", {31'd0, stallA}, 32'd1);
        cpu_en = 1'b0;
        repeat (5) cyc();
        settle();
        check("frz_stall_held", {31'd0, stallA}, 32'd1);
        check("frz_stallCnt", stallCntA, 32'd1);
        check("frz_pend", {28'd0, pendA}, 32'd1);
        cpu_en = 1'b1;
        cyc();
        settle();
        check("frz_resolved", {31'd0, stallA}, 32'd0);
        check("frz_fwdRs", {30'd0, fwdRsA}, 32'd2);
        check("frz_stallCnt2", stallCntA, 32'd2);
        drain();

        // reset mid-stall on the default instance
        setId(1'b1, 1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc();
        setId(1'b1, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 5'd0, 1'b0);
        settle();
        check("rstA_pre_stall", {31'd0, stallA}, 32'd1);
        rst = 1'b1;
        settle();
        check("rstA_stall_during", {31'd0, stallA}, 32'd0);
        cyc();
        rst = 1'b0;
        settle();
        check("rstA_stall_after", {31'd0, stallA}, 32'd0);
        check("rstA_stallCnt", stallCntA, 32'd0);
        check("rstA_pend", {28'd0, pendA}, 32'd0);

        // deep instance: three stall cycles, then reset mid-stall
        setId(1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc();
        setId(1'b1, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 5'd0, 1'b0);
        settle();
        check("B_stall_s1", {31'd0, stallB}, 32'd1);
        cyc();
        settle();
        check("B_stall_s2", {31'd0, stallB}, 32'd1);
        cyc();
        settle();
        check("B_stall_s3", {31'd0, stallB}, 32'd1);
        cyc();
        settle();
        check("B_stall_s4", {31'd0, stallB}, 32'd0);
        check("B_fwdRs", {29'd0, fwdRsB}, 32'd4);
        check("B_stallCnt", stallCntB, 32'd3);
        check("B_pend", {28'd0, pendB}, 32'd1);
        cyc();
        setId(1'b1, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc();
        setId(1'b1, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
        cyc();
        settle();
        check("B_mid_stall", {31'd0, stallB}, 32'd1);
        check("B_mid_stallCnt", stallCntB, 32'd4);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        settle();
        check("B_rst_stall", {31'd0, stallB}, 32'd0);
        check("B_rst_stallCnt", stallCntB, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
- REQ-001 Parameter ADDR_W, default 5, meaning register-address width.
- REQ-002 Parameter DEPTH, default 3, meaning in-flight stages after ID that are tracked (1=EX ... DEPTH=WB); legal range 2..8.
- REQ-003 Parameter LOAD_READY, default 2, meaning first stage index whose load data is forwardable; legal range 1..DEPTH.
- REQ-004 Parameter SEL_W, default $clog2(DEPTH+1), meaning forward-select width.
- REQ-005 clk  in  1  sole clock, rising edge.
- REQ-006 rst  in  1  reset, synchronous, active-high.
- REQ-007 cpu_en  in  1  pipeline advance enable; 0 freezes all state.
- REQ-008 id_valid  in  1  ID holds a real instruction.
- REQ-009 id_flush  in  1  ID instruction is squashed this cycle.
- REQ-010 id_rs, id_rt  in  ADDR_W each  ID source addresses.
- REQ-011 id_useRs, id_useRt  in  1 each  source actually read.
- REQ-012 id_ifWriteRegsFile  in  1  ID instruction writes the register file.
- REQ-013 id_registerWriteAddress  in  ADDR_W  ID destination.
- REQ-014 id_isLoad  in  1  ID instruction is a load.
- REQ-015 shouldStall  out  1  hold PC and IF/ID; bubble into EX.
- REQ-016 fwdSelRs, fwdSelRt  out  SEL_W each  0=register file, k=forward from stage k.
- REQ-017 stallCount  out  32  cycles stalled since reset.
- REQ-018 pendingCount  out  4  valid writer records in flight.

Function
- REQ-019 State is a DEPTH-entry record chain {valid, dest, isLoad}; entry 1 is youngest.
- REQ-020 On each rising edge with cpu_en=1 and rst=0, entry k+1 takes entry k, and entry DEPTH is discarded.
- REQ-021 Entry 1 takes the ID record when id_valid=1, id_flush=0, shouldStall=0, id_ifWriteRegsFile=1 and destination!=0; otherwise entry 1 takes a bubble (valid=0).
- REQ-022 Destination 0 is never tracked.
- REQ-023 For each source with use=1 and address!=0, the match is the lowest-index valid entry whose dest equals the source address.
- REQ-024 For an unused source or a source of address 0, select=0 and the source does not stall.
- REQ-025 A source hazards when its match is a load in stage < LOAD_READY.
- REQ-026 shouldStall = id_valid & ~id_flush & (rs hazard | rt hazard), combinational, same cycle.
- REQ-027 With no hazard, fwdSel equals the match stage index, or 0 if there is no match.
- REQ-028 While stalling, fwdSel is don't-care.
- REQ-029 Stall resolution latency: a load in stage 1 produces exactly LOAD_READY-1 stall cycles for a dependent instruction in ID.
- REQ-030 stallCount increments by 1 on each edge with cpu_en=1 and shouldStall=1, and saturates at 32'hFFFF_FFFF.
- REQ-031 pendingCount equals the popcount of entry valid bits, registered together with the chain.
- REQ-032 With cpu_en=0, the chain, stallCount and pendingCount hold; outputs still evaluate combinationally from the held state.
- REQ-033 id_flush and a hazard on the same cycle give shouldStall=0 and insert a bubble.

Reset
- REQ-034 rst=1 at an edge clears all valid bits, dest and isLoad to 0, and sets stallCount=0 and pendingCount=0, regardless of cpu_en.
- REQ-035 During and right after reset, shouldStall=0 and fwdSelRs=fwdSelRt=0.
- REQ-036 Reset mid-stall drops the stall on the next cycle.

Structure
- REQ-037 Shared package hazard_pkg holds the record typedef {valid, dest, isLoad} and the forward-select encoding constant FWD_REGFILE=0.
- REQ-038 One sub-module, hazard_match: a combinational priority matcher instanced once per source, returning the match stage, its isLoad bit and a hit flag.

Verification
- REQ-039 Issue add r3 followed by add r4,r3,r5 -> fwdSelRs=1 and shouldStall=0.
- REQ-040 Issue lw r2 followed by a user of r2, with LOAD_READY=2 -> 1 stall cycle, then fwdSel=2; stallCount=1.
- REQ-041 Issue writers r7 in stages 1 and 3 and read r7 -> fwdSel=1 (youngest wins).
- REQ-042 Issue a writer to r0, then read r0 -> fwdSel=0, no stall, pendingCount unchanged.
- REQ-043 Hold cpu_en=0 for 5 cycles during a load-use stall -> state frozen, stallCount unchanged; raise cpu_en -> stall resolves after 1 cycle.
- REQ-044 DEPTH=5, LOAD_READY=4, load-use pair -> 3 stall cycles; then assert rst mid-stall -> shouldStall=0 next cycle and stallCount=0.
